// File: rtl/fpga_pkg.sv
// Shared constants for the fixed-pinout LUT fabric: cell count, pad map and
// the default truth tables.
package fpga_pkg;

  localparam int NUM_CELLS     = 8;

  localparam int PAD_A         = 1;
  localparam int PAD_B         = 2;
  localparam int PAD_C         = 62;
  localparam int PAD_D         = 63;
  localparam int PAD_OE        = 64;
  localparam int PAD_COMB_BASE = 3;
  localparam int PAD_REG_BASE  = 11;

  // cell7 .. cell0; index into each table is {D,C,B,A}
  localparam logic [16*NUM_CELLS-1:0] LUT_INIT_DEFAULT = {
    16'h8000, 16'hCACA, 16'hE8E8, 16'h6996,
    16'h7777, 16'h6666, 16'hEEEE, 16'h8888
  };

endpackage

// File: rtl/lut4_cell.sv
// Single 4-input lookup cell: the output is the INIT bit selected by idx.
module lut4_cell #(
  parameter logic [15:0] INIT = 16'h0000
) (
  input  logic [3:0] idx,
  output logic       f
);

  assign f = INIT[idx];

endmodule

// File: rtl/fpga_fabric.sv
// Eight LUT cells fed from four input pads; results driven onto the pad ring
// both combinationally and through a one-cycle register, gated by OE.
module fpga_fabric
  import fpga_pkg::*;
#(
  parameter logic [16*NUM_CELLS-1:0] LUT_INIT = LUT_INIT_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  inout  wire [1:64] io
);

  logic [3:0]           idx;
  logic                 oe;
  logic [NUM_CELLS-1:0] f;
  logic [NUM_CELLS-1:0] q;

  assign idx = {io[PAD_D], io[PAD_C], io[PAD_B], io[PAD_A]};
  assign oe  = io[PAD_OE];

  for (genvar k = 0; k < NUM_CELLS; k++) begin : g_cell
    lut4_cell #(
      .INIT (LUT_INIT[16*k +: 16])
    ) u_cell (
      .idx (idx),
      .f   (f[k])
    );
  end

  // q is deliberately left unreset until the first edge so X is visible.
  always_ff @(posedge clk) begin
    if (rst) q <= '0;
    else     q <= f;
  end

  for (genvar k = 0; k < NUM_CELLS; k++) begin : g_pad
    assign io[PAD_COMB_BASE + k] = oe ? f[k] : 1'bz;
    assign io[PAD_REG_BASE + k]  = oe ? q[k] : 1'bz;
  end

  assign io[PAD_A]  = 1'bz;
  assign io[PAD_B]  = 1'bz;
  assign io[PAD_C]  = 1'bz;
  assign io[PAD_D]  = 1'bz;
  assign io[PAD_OE] = 1'bz;

  for (genvar p = PAD_REG_BASE + NUM_CELLS; p < PAD_C; p++) begin : g_unused
    assign io[p] = 1'bz;
  end

endmodule

// File: tb/tb_fpga_fabric.sv
// Directed bench for fpga_fabric: table of input patterns with hand-computed
// LUT results, plus sequences for reset, OE gating and a custom LUT_INIT.
module tb_fpga_fabric;
  import fpga_pkg::*;

  typedef struct {
    logic       a, b, c, d;
    logic [7:0] exp_f;   // bit k = cell k
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic a, b, c, d, oe;
  logic a2, b2, c2, d2, oe2;
  wire [1:64] io;
  wire [1:64] io2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign io[PAD_A]  = a;
  assign io[PAD_B]  = b;
  assign io[PAD_C]  = c;
  assign io[PAD_D]  = d;
  assign io[PAD_OE] = oe;

  assign io2[PAD_A]  = a2;
  assign io2[PAD_B]  = b2;
  assign io2[PAD_C]  = c2;
  assign io2[PAD_D]  = d2;
  assign io2[PAD_OE] = oe2;

  fpga_fabric u_dut (
    .clk (clk),
    .rst (rst),
    .io  (io)
  );

  fpga_fabric #(
    .LUT_INIT ({128{1'b1}})
  ) u_dut_ones (
    .clk (clk),
    .rst (1'b0),
    .io  (io2)
  );

  wire [7:0] comb_pads, reg_pads, comb2_pads, reg2_pads;
  for (genvar k = 0; k < 8; k++) begin : g_rd
    assign comb_pads[k]  = io[PAD_COMB_BASE + k];
    assign reg_pads[k]   = io[PAD_REG_BASE + k];
    assign comb2_pads[k] = io2[PAD_COMB_BASE + k];
    assign reg2_pads[k]  = io2[PAD_REG_BASE + k];
  end

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic va, vb, vc, vd);
    a = va; b = vb; c = vc; d = vd;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Released pads must not be driven high by the fabric.
  task automatic check_released(input string name);
    int hi;
    hi = 0;
    for (int p = PAD_COMB_BASE; p < PAD_REG_BASE + 8; p++)
      if (io[p] === 1'b1) hi++;
    checks++;
    if (hi != 0) begin
      errors++;
      $display("FAIL %s: %0d pads driven high, expected 0", name, hi);
    end
  endtask

  vec_t vecs[10];

  initial begin
    vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h08};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h4E};
    vecs[2] = '{1'b1, 1'b1, 1'b1, 1'b1, 8'hE3};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h63};
    vecs[4] = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h6E};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h5E};
    vecs[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h18};
    vecs[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h18};
    vecs[8] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h2E};
    vecs[9] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h1E};

    rst = 1'b1; oe = 1'b1;
    a2 = 1'b0; b2 = 1'b0; c2 = 1'b0; d2 = 1'b0; oe2 = 1'b1;
    set_in(1'b0, 1'b0, 1'b0, 1'b0);

    // Reset state
    tick();
    check8("reset_q", reg_pads, 8'h00);
    rst = 1'b0;

    // Combinational table, then registered copy one edge later
    foreach (vecs[i]) begin
      @(negedge clk);
      set_in(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].d);
      check8($sformatf("comb_v%0d", i), comb_pads, vecs[i].exp_f);
      tick();
      check8($sformatf("reg_v%0d", i), reg_pads, vecs[i].exp_f);
    end

    // Pre-edge hold after reset, then one-cycle latency
    @(negedge clk);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    set_in(1'b0, 1'b1, 1'b1, 1'b0);
    check8("pre_edge_q", reg_pads, 8'h00);
    check8("pre_edge_comb", comb_pads, 8'h6E);
    tick();
    check8("post_edge_q", reg_pads, 8'h6E);

    // Reset mid-stream: q clears, combinational pads keep tracking
    @(negedge clk);
    set_in(1'b1, 1'b1, 1'b1, 1'b1);
    tick();
    check8("mid_q_loaded", reg_pads, 8'hE3);
    @(negedge clk);
    rst = 1'b1;
    set_in(1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    check8("mid_rst_q", reg_pads, 8'h00);
    check8("mid_rst_comb", comb_pads, 8'h5E);
    @(negedge clk);
    rst = 1'b0;

    // OE gating; q keeps its value across the toggle
    set_in(1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    @(negedge clk);
    oe = 1'b0;
    #1;
    check_released("oe_off");
    @(negedge clk);
    oe = 1'b1;
    #1;
    check8("oe_back_comb", comb_pads, 8'h63);
    check8("oe_back_q", reg_pads, 8'h63);

    // Pads outside the output ranges stay undriven while outputs are high
    set_in(1'b1, 1'b1, 1'b1, 1'b1);
    begin
      int hi;
      hi = 0;
      for (int p = PAD_REG_BASE + 8; p < PAD_C; p++)
        if (io[p] === 1'b1) hi++;
      checks++;
      if (hi != 0) begin
        errors++;
        $display("FAIL unused_pads: %0d driven high, expected 0", hi);
      end
    end

    // All-ones truth tables: every input combination gives all ones
    for (int n = 0; n < 16; n++) begin
      logic [3:0] v;
      v = n[3:0];
      a2 = v[0]; b2 = v[1]; c2 = v[2]; d2 = v[3];
      #1;
      check8($sformatf("ones_comb_%0d", n), comb2_pads, 8'hFF);
    end
    tick();
    check8("ones_q", reg2_pads, 8'hFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
